// File: rtl/sparse_encoder_par.sv
// sparse_encoder_par
//   Encodes one sample of FEATURE_COUNT level hypervectors into one HV_DIM-bit
//   hypervector. Feature i is bound by a circular left rotation of i bits. Each
//   bit position keeps a count of the bound features that set it, LANES
//   features per cycle. At the end the counts are thresholded (mode 0) or
//   ORed (mode 1).
// Ports
//   clk, nrst        : clock (rising edge), asynchronous active-low reset
//   en               : global clock enable; all state freezes while low
//   start_encoding   : request to encode one sample (ignored while busy)
//   thr, mode        : bit-count threshold / output rule, latched at start
//   level_HVs        : FEATURE_COUNT input hypervectors, stable while busy
//   busy             : high from start acceptance until encoding_done
//   encoding_done    : one-cycle completion pulse
//   encoded_HV       : result, held until the next completion
module sparse_encoder_par #(
    parameter int HV_DIM        = 64,
    parameter int FEATURE_COUNT = 40,
    parameter int LANES         = 4,
    parameter int CNT_W         = $clog2(FEATURE_COUNT + 1),
    parameter int NGRP          = (FEATURE_COUNT + LANES - 1) / LANES
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              start_encoding,
    input  logic [CNT_W-1:0]  thr,
    input  logic              mode,
    input  logic [HV_DIM-1:0] level_HVs [0:FEATURE_COUNT-1],
    output logic              busy,
    output logic              encoding_done,
    output logic [HV_DIM-1:0] encoded_HV
);

    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int NPAD = NGRP * LANES;

    typedef enum logic [1:0] {IDLE, ACCUM, THRESH} state_t;

    state_t                         r_state, w_next;
    logic [GW-1:0]                  r_g;
    logic [HV_DIM-1:0][CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]               r_thr;
    logic                           r_mode;
    logic                           r_done;
    logic [HV_DIM-1:0]              r_enc;

    logic [HV_DIM-1:0]              w_bound [0:NPAD-1];
    logic [HV_DIM-1:0]              w_lane  [0:LANES-1];
    logic [HV_DIM-1:0][CNT_W-1:0]   w_sum;
    logic [HV_DIM-1:0]              w_bit;
    logic                           w_accept;
    logic                           w_last;

    // Binding rotations are constant per feature, so they are pure wiring.
    // The feature list is padded with zeros up to a whole number of groups.
    for (genvar i = 0; i < NPAD; i++) begin : g_bind
        if (i < FEATURE_COUNT) begin : g_real
            localparam int R = i % HV_DIM;
            logic [2*HV_DIM-1:0] w_dbl;
            assign w_dbl      = {level_HVs[i], level_HVs[i]};
            assign w_bound[i] = w_dbl[2*HV_DIM-1-R -: HV_DIM];
        end else begin : g_pad
            assign w_bound[i] = '0;
        end
    end

    // Group select: lane l takes feature g*LANES + l.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane[l] = '0;
            for (int g = 0; g < NGRP; g++) begin
                if (r_g == GW'(g)) w_lane[l] = w_bound[g*LANES + l];
            end
        end
    end

    // Per-bit popcount across the lanes of the current group.
    always_comb begin
        for (int b = 0; b < HV_DIM; b++) begin
            w_sum[b] = '0;
            for (int l = 0; l < LANES; l++) begin
                w_sum[b] = w_sum[b] + CNT_W'(w_lane[l][b]);
            end
        end
    end

    always_comb begin
        for (int b = 0; b < HV_DIM; b++) begin
            w_bit[b] = r_mode ? (r_cnt[b] != '0) : (r_cnt[b] >= r_thr);
        end
    end

    // r_done blocks a start arriving in the same cycle as the done pulse.
    assign w_accept = (r_state == IDLE) && start_encoding && !r_done;
    assign w_last   = (r_g == GW'(NGRP - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ACCUM;
            ACCUM:   if (w_last)   w_next = THRESH;
            THRESH:                w_next = IDLE;
            default:               w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)   r_state <= IDLE;
        else if (en) r_state <= w_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_g    <= '0;
            r_cnt  <= '0;
            r_thr  <= '0;
            r_mode <= 1'b0;
            r_done <= 1'b0;
            r_enc  <= '0;
        end else begin
            // Pulse is not frozen by en: it lasts exactly one cycle and only
            // fires on an enabled THRESH edge.
            r_done <= en && (r_state == THRESH);
            if (en) begin
                case (r_state)
                    IDLE: if (w_accept) begin
                        r_thr  <= thr;
                        r_mode <= mode;
                        r_cnt  <= '0;
                        r_g    <= '0;
                    end
                    ACCUM: begin
                        for (int b = 0; b < HV_DIM; b++) r_cnt[b] <= r_cnt[b] + w_sum[b];
                        r_g <= w_last ? '0 : r_g + GW'(1);
                    end
                    THRESH: r_enc <= w_bit;
                    default: ;
                endcase
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign encoding_done = r_done;
    assign encoded_HV    = r_enc;

endmodule

// File: tb/tb_sparse_encoder_par.sv
// Self-checking bench for sparse_encoder_par. Three instances (LANES = 1, 4,
// 40) share all inputs; each result and latency is compared with a
// rotate-and-count reference model.
module tb_sparse_encoder_par;

    localparam int D = 64;
    localparam int F = 40;
    localparam int CW = 6;
    localparam int ENCODING_BIT_THR = 20;

    logic          clk = 1'b0;
    logic          nrst, en, start;
    logic [CW-1:0] thr;
    logic          mode;
    logic [D-1:0]  hv [0:F-1];
    logic [2:0]    busy, done;
    logic [D-1:0]  enc [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sparse_encoder_par #(.HV_DIM(D), .FEATURE_COUNT(F), .LANES(1)) u_l1 (
        .clk(clk), .nrst(nrst), .en(en), .start_encoding(start), .thr(thr), .mode(mode),
        .level_HVs(hv), .busy(busy[0]), .encoding_done(done[0]), .encoded_HV(enc[0]));
    sparse_encoder_par #(.HV_DIM(D), .FEATURE_COUNT(F), .LANES(4)) u_l4 (
        .clk(clk), .nrst(nrst), .en(en), .start_encoding(start), .thr(thr), .mode(mode),
        .level_HVs(hv), .busy(busy[1]), .encoding_done(done[1]), .encoded_HV(enc[1]));
    sparse_encoder_par #(.HV_DIM(D), .FEATURE_COUNT(F), .LANES(40)) u_l40 (
        .clk(clk), .nrst(nrst), .en(en), .start_encoding(start), .thr(thr), .mode(mode),
        .level_HVs(hv), .busy(busy[2]), .encoding_done(done[2]), .encoded_HV(enc[2]));

    function automatic int ngrp(input int j);
        return (j == 0) ? 40 : (j == 1) ? 10 : 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: rotate each feature left by its index, count per bit, apply rule.
    function automatic logic [D-1:0] golden(input logic [CW-1:0] t, input logic m);
        int           cnt [D];
        logic [D-1:0] r, res;
        int           s;
        for (int b = 0; b < D; b++) cnt[b] = 0;
        for (int i = 0; i < F; i++) begin
            s = i % D;
            r = (s == 0) ? hv[i] : ((hv[i] << s) | (hv[i] >> (D - s)));
            for (int b = 0; b < D; b++) cnt[b] += int'(r[b]);
        end
        for (int b = 0; b < D; b++) res[b] = m ? (cnt[b] != 0) : (cnt[b] >= int'(t));
        return res;
    endfunction

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy == 3'b000 && done == 3'b000) break;
        end
        @(negedge clk);
    endtask

    // One sample: edges k >= 1 after the start-sampling edge; en low on edges
    // lo_at .. lo_at+lo_len-1; optional second start (with changed thr/mode)
    // on edge 3 that must be ignored.
    task automatic run_sample(input string tag, input logic [D-1:0] exp,
                              input int lo_at, input int lo_len, input bit poke);
        bit seen [3];
        int exp_lat [3];
        int ecnt;
        for (int j = 0; j < 3; j++) begin
            seen[j] = 1'b0;
            ecnt = 0;
            exp_lat[j] = -1;
            for (int k = 1; k < 200; k++) begin
                if (!(k >= lo_at && k < lo_at + lo_len)) ecnt++;
                if (ecnt == ngrp(j) + 1) begin exp_lat[j] = k; break; end
            end
        end
        en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            en = !(k >= lo_at && k < lo_at + lo_len);
            if (poke && k == 3) begin start = 1'b1; thr = ~thr; mode = ~mode; end
            else if (poke && k == 4) begin start = 1'b0; thr = ~thr; mode = ~mode; end
            else start = 1'b0;
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (!seen[j] && done[j]) begin
                    seen[j] = 1'b1;
                    chk($sformatf("%s_lat%0d", tag, j), 64'(k), 64'(exp_lat[j]));
                    chk($sformatf("%s_hv%0d", tag, j), enc[j], exp);
                    chk($sformatf("%s_busy%0d", tag, j), 64'(busy[j]), 64'd0);
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int j = 0; j < 3; j++)
            if (!seen[j]) chk($sformatf("%s_timeout%0d", tag, j), 64'd0, 64'd1);
        en = 1'b1; start = 1'b0;
        drain();
    endtask

    task automatic rand_hv();
        for (int i = 0; i < F; i++) hv[i] = {$urandom, $urandom};
    endtask

    initial begin
        int first [3];
        int second [3];
        int ndone;

        nrst = 1'b0; en = 1'b1; start = 1'b0; thr = '0; mode = 1'b0;
        for (int i = 0; i < F; i++) hv[i] = '0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rst_busy%0d", j), 64'(busy[j]), 64'd0);
            chk($sformatf("rst_done%0d", j), 64'(done[j]), 64'd0);
            chk($sformatf("rst_hv%0d", j), enc[j], 64'd0);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // All zero inputs, thr=1
        thr = 6'd1; mode = 1'b0;
        run_sample("zero", 64'd0, 0, 0, 1'b0);

        // All ones: thr=40 -> ones, thr=41 -> zeros
        for (int i = 0; i < F; i++) hv[i] = '1;
        thr = 6'd40;
        run_sample("ones40", {D{1'b1}}, 0, 0, 1'b0);
        thr = 6'd41;
        run_sample("ones41", 64'd0, 0, 0, 1'b0);
        thr = 6'd0;
        run_sample("thr0", {D{1'b1}}, 0, 0, 1'b0);

        // Single feature: binding rotation check
        for (int i = 0; i < F; i++) hv[i] = '0;
        hv[3] = 64'h1;
        mode = 1'b1; thr = 6'd0;
        run_sample("single_or", 64'h8, 0, 0, 1'b0);
        mode = 1'b0; thr = 6'd2;
        run_sample("single_thr", 64'h0, 0, 0, 1'b0);

        // Random samples against the reference
        mode = 1'b0; thr = 6'(ENCODING_BIT_THR);
        rand_hv();
        run_sample("rnd_a", golden(thr, mode), 0, 0, 1'b0);
        rand_hv();
        run_sample("rnd_enlow", golden(thr, mode), 2, 3, 1'b0);
        rand_hv();
        run_sample("rnd_poke", golden(thr, mode), 0, 0, 1'b1);
        for (int i = 0; i < F; i++) hv[i] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        mode = 1'b1;
        run_sample("rnd_or", golden(thr, mode), 0, 0, 1'b0);
        mode = 1'b0; thr = 6'(ENCODING_BIT_THR - 4);
        run_sample("rnd_sparse", golden(thr, mode), 0, 0, 1'b0);

        // start held high: start coincident with done is ignored, next accepted
        thr = 6'(ENCODING_BIT_THR); mode = 1'b0;
        rand_hv();
        for (int j = 0; j < 3; j++) begin first[j] = -1; second[j] = -1; end
        start = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (done[j]) begin
                    if (first[j] < 0) first[j] = k;
                    else if (second[j] < 0) second[j] = k;
                end
            end
        end
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("held_first%0d", j), 64'(first[j]), 64'(ngrp(j) + 2));
            chk($sformatf("held_gap%0d", j), 64'(second[j] - first[j]), 64'(ngrp(j) + 3));
        end
        drain();

        // Restart attempt while busy, then reset mid-accumulation
        rand_hv();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nrst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hv1", enc[1], 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done != 3'b000) ndone++;
        end
        chk("post_rst_nodone", 64'(ndone), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_hv0", enc[0], 64'd0);
        run_sample("after_rst", golden(thr, mode), 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sparse_encoder_par.md
SPARSE_ENCODER_PAR -- requirements
Module: sparse_encoder_par

Interface
REQ-001 The block SHALL have parameter HV_DIM, default 64, meaning hypervector width in bits.
REQ-002 The block SHALL have parameter FEATURE_COUNT, default 40, meaning number of level HVs per sample.
REQ-003 The block SHALL have parameter LANES, default 4, meaning features accumulated per cycle (1..FEATURE_COUNT).
REQ-004 The block SHALL have derived parameters CNT_W = $clog2(FEATURE_COUNT+1) and NGRP = ceil(FEATURE_COUNT/LANES).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-006 The block SHALL have port nrst, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit, global clock-enable; all state freezes while low.
REQ-008 The block SHALL have port start_encoding, input, 1 bit, request to encode one sample.
REQ-009 The block SHALL have port thr, input, CNT_W bits, bit-count threshold, sampled at start.
REQ-010 The block SHALL have port mode, input, 1 bit, output rule: 0 = threshold (count >= thr), 1 = OR (count != 0); sampled at start.
REQ-011 The block SHALL have port level_HVs, input, unpacked array [0:FEATURE_COUNT-1] of HV_DIM bits, held stable by the source while busy is high.
REQ-012 The block SHALL have port busy, output, 1 bit, high from start acceptance until encoding_done.
REQ-013 The block SHALL have port encoding_done, output, 1 bit, single-cycle completion pulse.
REQ-014 The block SHALL have port encoded_HV, output, HV_DIM bits, encoded result, held until the next completion.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, THRESH; transitions occur only on rising edges with en=1.
REQ-016 In IDLE, start_encoding=1 with en=1 SHALL latch thr and mode, clear all HV_DIM counters and group index g, and enter ACCUM.
REQ-017 The block SHALL ignore start_encoding while busy; no restart and no latched-value change.
REQ-018 Binding: feature i SHALL contribute rotl(level_HVs[i], i mod HV_DIM), a circular left rotation by i bits.
REQ-019 Each ACCUM cycle SHALL add, per bit position b, the count of set bit b among bound features g*LANES .. g*LANES+LANES-1; indices >= FEATURE_COUNT contribute 0.
REQ-020 Counters SHALL be CNT_W bits and cannot overflow, since the maximum count is FEATURE_COUNT.
REQ-021 ACCUM SHALL advance g each enabled cycle and move to THRESH after the group NGRP-1 cycle.
REQ-022 THRESH SHALL load encoded_HV[b] per the latched mode/thr, pulse encoding_done for exactly one cycle, drop busy in the same cycle, and return to IDLE.
REQ-023 Latency: with en continuously high, encoding_done SHALL be high in the cycle following the (NGRP+1)th rising edge after the edge that samples start; each en-low cycle extends this by one.
REQ-024 While en=0, encoding_done SHALL stay low; a pending pulse is emitted only after en returns and THRESH executes.
REQ-025 Boundaries: thr=0 in mode 0 SHALL give all ones; thr > FEATURE_COUNT SHALL give all zeros; LANES=FEATURE_COUNT SHALL give NGRP=1.
REQ-026 A start_encoding asserted in the same cycle as encoding_done SHALL be ignored; a new start is accepted no earlier than the following cycle.

Reset
REQ-027 nrst=0 SHALL asynchronously force IDLE, busy=0, encoding_done=0, encoded_HV=0, counters=0, g=0, latched thr=0, latched mode=0.
REQ-028 Reset asserted mid-ACCUM SHALL abort the sample with no done pulse; after release, a new start SHALL behave as from power-up.

Verification
REQ-029 All level_HVs = 0, thr=1, mode 0 (F=40, D=64, L=4) -> done one cycle after the 11th edge following start, encoded_HV = 0.
REQ-030 All level_HVs = all-ones, thr=40, mode 0 -> encoded_HV = all ones; same stimulus with thr=41 -> all zeros.
REQ-031 Only level_HVs[3] = 64'h1, mode 1 -> encoded_HV = 64'h8 (rotated by 3); with mode 0 and thr=2 -> 0.
REQ-032 Random level_HVs with thr=ENCODING_BIT_THR, against a golden rotate-and-count model, for L in {1,4,40}, including one sample with en low for 3 mid-ACCUM cycles -> bit-exact result, latency +3.
REQ-033 start pulsed again during busy, then nrst low for 1 cycle mid-ACCUM -> second start ignored, no done, outputs 0, next sample correct.
